// File: rtl/mlp_cmd_pkg.sv
// Shared opcodes, FSM states and MLP state encodings for the MLP command loader.
package mlp_cmd_pkg;

    localparam logic [7:0] OP_LOAD_WEIGHTS = 8'h01;
    localparam logic [7:0] OP_LOAD_ACT     = 8'h02;
    localparam logic [7:0] OP_START        = 8'h03;
    localparam logic [7:0] OP_CONFIG       = 8'h04;
    localparam logic [7:0] OP_WF_RESET     = 8'h05;

    localparam int CFG_BYTES = 10;

    localparam logic [3:0] MLP_IDLE        = 4'd0;
    localparam logic [3:0] MLP_LOAD_WEIGHT = 4'd1;
    localparam logic [3:0] MLP_DONE        = 4'd8;

    typedef enum logic [2:0] {
        S_OPCODE,
        S_WT,
        S_ACT_CNT,
        S_ACT_LO,
        S_ACT_HI,
        S_CFG,
        S_EXEC
    } state_t;

endpackage

// File: rtl/mlp_cmd_loader.sv
// Byte-stream command sequencer producing MLP control strobes and config registers.
// Latency: a payload byte accepted at t shows its strobe at t+1; S_EXEC adds one cycle per command.
// Backpressure: in_ready is low only during the single S_EXEC cycle.
module mlp_cmd_loader
    import mlp_cmd_pkg::*;
#(
    parameter int ROWS     = 2,
    parameter int MAX_VECS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic [3:0]         mlp_state,
    input  logic               mlp_layer_complete,
    output logic               wf_push_col0,
    output logic               wf_push_col1,
    output logic [7:0]         wf_data_in,
    output logic               wf_reset,
    output logic               init_act_valid,
    output logic [15:0]        init_act_data,
    output logic               start_mlp,
    output logic               weights_ready,
    output logic signed [15:0] norm_gain,
    output logic signed [31:0] norm_bias,
    output logic [4:0]         norm_shift,
    output logic signed [15:0] q_inv_scale,
    output logic signed [7:0]  q_zero_point,
    output logic               busy,
    output logic               err,
    output logic               cmd_done
);

    localparam logic [7:0] WT_LAST  = 8'(2 * ROWS - 1);
    localparam logic [7:0] CFG_LAST = 8'(CFG_BYTES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  act_left;
    logic [7:0]  act_lo;
    logic [71:0] cfg_sh;     // first nine CONFIG bytes; the tenth is taken straight from in_data
    logic        run_active;
    logic        accept;
    logic        to_exec;

    assign accept = in_valid && in_ready;

    always_comb begin
        to_exec = 1'b0;
        if (accept) begin
            case (state)
                S_OPCODE: to_exec = (in_data == OP_START) || (in_data == OP_WF_RESET);
                S_WT:     to_exec = (cnt == WT_LAST);
                S_ACT_HI: to_exec = (act_left == 8'd1);
                S_CFG:    to_exec = (cnt == CFG_LAST);
                default:  to_exec = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_OPCODE;
            cnt            <= '0;
            act_left       <= '0;
            act_lo         <= '0;
            cfg_sh         <= '0;
            run_active     <= 1'b0;
            in_ready       <= 1'b1;
            wf_push_col0   <= 1'b0;
            wf_push_col1   <= 1'b0;
            wf_data_in     <= '0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            init_act_data  <= '0;
            start_mlp      <= 1'b0;
            weights_ready  <= 1'b0;
            norm_gain      <= 16'sh0100;
            norm_bias      <= '0;
            norm_shift     <= 5'd8;
            q_inv_scale    <= 16'sh0100;
            q_zero_point   <= '0;
            busy           <= 1'b0;
            err            <= 1'b0;
            cmd_done       <= 1'b0;
        end else begin
            wf_push_col0   <= 1'b0;
            wf_push_col1   <= 1'b0;
            wf_reset       <= 1'b0;
            init_act_valid <= 1'b0;
            start_mlp      <= 1'b0;
            cmd_done       <= 1'b0;

            if (mlp_layer_complete)
                run_active <= 1'b0;
            if (weights_ready && mlp_state == MLP_LOAD_WEIGHT)
                weights_ready <= 1'b0;

            case (state)
                S_OPCODE: if (accept) begin
                    cnt <= '0;
                    case (in_data)
                        OP_LOAD_WEIGHTS: begin state <= S_WT;      busy <= 1'b1; end
                        OP_LOAD_ACT:     begin state <= S_ACT_CNT; busy <= 1'b1; end
                        OP_CONFIG:       begin state <= S_CFG;     busy <= 1'b1; end
                        OP_START: begin
                            // run_active here is the pre-clear value when layer_complete coincides
                            if (run_active || !(mlp_state == MLP_IDLE || mlp_state == MLP_DONE)) begin
                                err <= 1'b1;
                            end else begin
                                start_mlp  <= 1'b1;
                                run_active <= 1'b1;
                            end
                        end
                        OP_WF_RESET: wf_reset <= 1'b1;
                        default:     err <= 1'b1;
                    endcase
                end
                S_WT: if (accept) begin
                    wf_data_in <= in_data;
                    if (cnt < 8'(ROWS)) wf_push_col0 <= 1'b1;
                    else                wf_push_col1 <= 1'b1;
                    cnt <= cnt + 8'd1;
                    if (cnt == WT_LAST && run_active)
                        weights_ready <= 1'b1;
                end
                S_ACT_CNT: if (accept) begin
                    if (in_data == 8'd0 || in_data > 8'(MAX_VECS)) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_OPCODE;
                    end else begin
                        act_left <= in_data;
                        state    <= S_ACT_LO;
                    end
                end
                S_ACT_LO: if (accept) begin
                    act_lo <= in_data;
                    state  <= S_ACT_HI;
                end
                S_ACT_HI: if (accept) begin
                    init_act_valid <= 1'b1;
                    init_act_data  <= {in_data, act_lo};
                    act_left       <= act_left - 8'd1;
                    state          <= S_ACT_LO;
                end
                S_CFG: if (accept) begin
                    cfg_sh <= {in_data, cfg_sh[71:8]};
                    cnt    <= cnt + 8'd1;
                    if (cnt == CFG_LAST) begin
                        norm_gain    <= cfg_sh[15:0];
                        norm_bias    <= cfg_sh[47:16];
                        norm_shift   <= cfg_sh[52:48];
                        q_inv_scale  <= cfg_sh[71:56];
                        q_zero_point <= in_data;
                    end
                end
                S_EXEC: begin
                    state    <= S_OPCODE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
                default: state <= S_OPCODE;
            endcase

            if (to_exec) begin
                state    <= S_EXEC;
                in_ready <= 1'b0;
                busy     <= 1'b1;
                cmd_done <= 1'b1;
            end
        end
    end

endmodule
